alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_mul_iter.sv | 48 ++++
 rtl/alu_seq.sv | 160 ++++++++++++++++
 tb/tb_alu_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and flag bit positions for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_LSL   = 4'b0011;
  localparam logic [3:0] OP_LSR   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low n bits kept.
module alu_mul_iter #(
  parameter int n     = 64,
  parameter int ITERS = n
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         done,
  output logic [n-1:0] product
);
  localparam int CW = $clog2(ITERS + 1);

  logic [n-1:0]  mcand;
  logic [n-1:0]  mplier;
  logic [n-1:0]  acc;
  logic [CW-1:0] cnt;
  logic          busy;

  // product includes this cycle's partial sum, so it is final while done is high
  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = busy && (cnt == CW'(ITERS - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes on both sides.
// Define ALU_SEQ_MUL_EN to add the iterative multiplier (opcode 1000).
module alu_seq
  import alu_pkg::*;
#(
  parameter int n          = 64,
  parameter int MUL_CYCLES = n
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         InValid,
  output logic         InReady,
  input  logic [n-1:0] BusA,
  input  logic [n-1:0] BusB,
  input  logic [3:0]   ALUCtrl,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [n-1:0] BusW,
  output logic [3:0]   Flags,
  output logic         Err
);
  localparam int ShW = $clog2(n);

  state_t         state, stateNext;
  logic           transfer, loadResult;
  logic [n:0]     addFull, subFull;
  logic [ShW-1:0] shAmt;
  logic [n-1:0]   aluW, resW;
  logic           aluC, aluV, aluErr;
  logic           resC, resV, resErr;
  logic [3:0]     resFlags;

  if (MUL_CYCLES != n || n < 8 || n > 64) begin : gBadParam
    $error("alu_seq: n must be 8..64 and MUL_CYCLES must equal n");
  end

  assign InReady  = (state == IDLE) && !Reset;
  assign OutValid = (state == DONE);
  assign transfer = InValid && InReady;

  // SUB as A + ~B + 1 so the carry-out is directly the not-borrow flag
  assign addFull = {1'b0, BusA} + {1'b0, BusB};
  assign subFull = {1'b0, BusA} + {1'b0, ~BusB} + {{n{1'b0}}, 1'b1};
  assign shAmt   = BusB[ShW-1:0];

  always_comb begin
    aluW   = '0;
    aluC   = 1'b0;
    aluV   = 1'b0;
    aluErr = 1'b0;
    case (ALUCtrl)
      OP_AND:   aluW = BusA & BusB;
      OP_OR:    aluW = BusA | BusB;
      OP_ADD: begin
        aluW = addFull[n-1:0];
        aluC = addFull[n];
        aluV = (BusA[n-1] == BusB[n-1]) && (addFull[n-1] != BusA[n-1]);
      end
      OP_SUB: begin
        aluW = subFull[n-1:0];
        aluC = subFull[n];
        aluV = (BusA[n-1] != BusB[n-1]) && (subFull[n-1] != BusA[n-1]);
      end
      OP_LSL:   aluW = BusA << shAmt;
      OP_LSR:   aluW = BusA >> shAmt;
      OP_PASSB: aluW = BusB;
      default:  aluErr = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  logic         mulStart, mulDone;
  logic [n-1:0] mulProduct;

  assign mulStart = transfer && (ALUCtrl == OP_MUL);

  alu_mul_iter #(
    .n     (n),
    .ITERS (MUL_CYCLES)
  ) uMul (
    .clock   (CLK),
    .reset   (Reset),
    .start   (mulStart),
    .a       (BusA),
    .b       (BusB),
    .done    (mulDone),
    .product (mulProduct)
  );
`endif

  always_comb begin
    stateNext  = state;
    loadResult = 1'b0;
    resW       = aluW;
    resC       = aluC;
    resV       = aluV;
    resErr     = aluErr;
    case (state)
      IDLE: begin
        if (transfer) begin
`ifdef ALU_SEQ_MUL_EN
          if (ALUCtrl == OP_MUL) begin
            stateNext = EXEC;
          end else begin
            stateNext  = DONE;
            loadResult = 1'b1;
          end
`else
          stateNext  = DONE;
          loadResult = 1'b1;
`endif
        end
      end
      EXEC: begin
`ifdef ALU_SEQ_MUL_EN
        if (mulDone) begin
          stateNext  = DONE;
          loadResult = 1'b1;
          resW       = mulProduct;
          resC       = 1'b0;
          resV       = 1'b0;
          resErr     = 1'b0;
        end
`else
        stateNext = IDLE;
`endif
      end
      DONE: begin
        if (OutReady) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    resFlags         = '0;
    resFlags[FLAG_N] = resW[n-1];
    resFlags[FLAG_Z] = (resW == '0);
    resFlags[FLAG_C] = resC;
    resFlags[FLAG_V] = resV;
  end

  // Results are captured once and held untouched through DONE
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= IDLE;
      BusW  <= '0;
      Flags <= '0;
      Err   <= 1'b0;
    end else begin
      state <= stateNext;
      if (loadResult) begin
        BusW  <= resW;
        Flags <= resFlags;
        Err   <= resErr;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed ops push expectations, a monitor pops and compares.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int N = 64;

  logic         CLK;
  logic         Reset;
  logic         InValid;
  logic         InReady;
  logic [N-1:0] BusA;
  logic [N-1:0] BusB;
  logic [3:0]   ALUCtrl;
  logic         OutValid;
  logic         OutReady;
  logic [N-1:0] BusW;
  logic [3:0]   Flags;
  logic         Err;

  typedef struct {
    string       name;
    logic [63:0] w;
    logic [3:0]  f;
    logic        e;
    int          lat;
    int          hold;
    int          xfer;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  alu_seq #(.n(N)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .InValid  (InValid),
    .InReady  (InReady),
    .BusA     (BusA),
    .BusB     (BusB),
    .ALUCtrl  (ALUCtrl),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .BusW     (BusW),
    .Flags    (Flags),
    .Err      (Err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s", name);
  endtask

  task automatic applyStimulus(input string name, input logic [3:0] op,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] w, input logic [3:0] f, input logic e,
                               input int lat, input int hold);
    exp_t x;
    int   waited = 0;
    @(negedge CLK);
    while (!InReady && waited < 300) begin
      @(negedge CLK);
      waited++;
    end
    if (!InReady) begin
      failNow({name, " InReady timeout"});
      return;
    end
    BusA    = a;
    BusB    = b;
    ALUCtrl = op;
    InValid = 1'b1;
    x.name = name;
    x.w    = w;
    x.f    = f;
    x.e    = e;
    x.lat  = lat;
    x.hold = hold;
    x.xfer = cyc + 1;
    sb.push_back(x);
    @(negedge CLK);
    // scramble inputs so an in-flight op that still looks at them is caught
    InValid = 1'b0;
    BusA    = ~a;
    BusB    = b ^ 64'hA5A5_5A5A_0F0F_F0F0;
    ALUCtrl = op ^ 4'b0101;
  endtask

  task automatic waitIdle(input string name);
    int waited = 0;
    @(negedge CLK);
    while ((sb.size() != 0 || OutValid) && waited < 500) begin
      @(negedge CLK);
      waited++;
    end
    if (sb.size() != 0 || OutValid) failNow({name, " drain timeout"});
  endtask

  // Consumer side: pops on each new result, then holds OutReady low for 'hold' cycles
  initial begin
    exp_t cur;
    bit   shown    = 0;
    int   holdLeft = 0;
    OutReady = 1'b0;
    forever begin
      @(negedge CLK);
      if (!OutValid) begin
        shown    = 0;
        OutReady = 1'b0;
      end else if (!shown) begin
        shown = 1;
        if (sb.size() == 0) begin
          failNow("unexpected OutValid with empty scoreboard");
          holdLeft = 0;
        end else begin
          cur = sb.pop_front();
          checkOutput({cur.name, " BusW"}, BusW, cur.w);
          checkOutput({cur.name, " Flags"}, 64'(Flags), 64'(cur.f));
          checkOutput({cur.name, " Err"}, 64'(Err), 64'(cur.e));
          checkOutput({cur.name, " latency"}, 64'(cyc - cur.xfer + 1), 64'(cur.lat));
          checkOutput({cur.name, " InReady in DONE"}, 64'(InReady), 64'd0);
          holdLeft = cur.hold;
        end
        OutReady = (holdLeft == 0);
      end else begin
        checkOutput({cur.name, " held BusW"}, BusW, cur.w);
        checkOutput({cur.name, " held Flags"}, 64'(Flags), 64'(cur.f));
        checkOutput({cur.name, " held InReady"}, 64'(InReady), 64'd0);
        if (holdLeft > 0) holdLeft--;
        OutReady = (holdLeft == 0);
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int sawValid;
    Reset   = 1'b1;
    InValid = 1'b0;
    BusA    = '0;
    BusB    = '0;
    ALUCtrl = 4'b0000;
    repeat (3) @(negedge CLK);
    checkOutput("reset InReady", 64'(InReady), 64'd0);
    checkOutput("reset OutValid", 64'(OutValid), 64'd0);
    checkOutput("reset BusW", BusW, 64'd0);
    checkOutput("reset Flags", 64'(Flags), 64'd0);
    checkOutput("reset Err", 64'(Err), 64'd0);
    Reset = 1'b0;
    @(negedge CLK);
    checkOutput("post-reset InReady", 64'(InReady), 64'd1);

    applyStimulus("add ovf", OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
                  64'h8000_0000_0000_0000, 4'b1001, 1'b0, 1, 0);
    applyStimulus("sub eq hold", OP_SUB, 64'd5, 64'd5, 64'd0, 4'b0110, 1'b0, 1, 3);
    applyStimulus("lsl", OP_LSL, 64'd1, 64'h43, 64'd8, 4'b0000, 1'b0, 1, 0);
    applyStimulus("lsr", OP_LSR, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 4'b0000, 1'b0, 1, 0);
`ifdef ALU_SEQ_MUL_EN
    applyStimulus("mul", OP_MUL, 64'h1234, 64'h10, 64'h12340, 4'b0000, 1'b0, 65, 0);
    applyStimulus("mul neg", OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
                  64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b0, 65, 1);
`else
    applyStimulus("mul unsup", OP_MUL, 64'h1234, 64'h10, 64'd0, 4'b0100, 1'b1, 1, 0);
`endif
    applyStimulus("op 1111", 4'b1111, 64'h55, 64'hAA, 64'd0, 4'b0100, 1'b1, 1, 0);
    applyStimulus("and clr err", OP_AND, 64'hF0, 64'h3C, 64'h30, 4'b0000, 1'b0, 1, 0);
    applyStimulus("or", OP_OR, 64'hF0, 64'h0F, 64'hFF, 4'b0000, 1'b0, 1, 0);
    applyStimulus("passb", OP_PASSB, 64'd123, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b0, 1, 0);
    applyStimulus("add carry", OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b0110, 1'b0, 1, 0);
    applyStimulus("sub borrow", OP_SUB, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b0, 1, 0);
    applyStimulus("sub ovf", OP_SUB, 64'h8000_0000_0000_0000, 64'd1,
                  64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 1'b0, 1, 2);
    applyStimulus("op 0101", 4'b0101, 64'd7, 64'd9, 64'd0, 4'b0100, 1'b1, 1, 0);
    waitIdle("pre-reset");

`ifdef ALU_SEQ_MUL_EN
    // launch a multiply with no expectation pushed: it must never complete
    BusA    = 64'h1234;
    BusB    = 64'h10;
    ALUCtrl = OP_MUL;
    InValid = 1'b1;
    @(negedge CLK);
    InValid = 1'b0;
    repeat (9) @(negedge CLK);
`endif
    Reset = 1'b1;
    @(negedge CLK);
    checkOutput("mid-reset InReady", 64'(InReady), 64'd0);
    checkOutput("mid-reset OutValid", 64'(OutValid), 64'd0);
    @(negedge CLK);
    Reset = 1'b0;
    @(negedge CLK);
    checkOutput("after reset InReady", 64'(InReady), 64'd1);
    checkOutput("after reset BusW", BusW, 64'd0);
    checkOutput("after reset Flags", 64'(Flags), 64'd0);
    sawValid = 0;
    repeat (80) begin
      @(negedge CLK);
      if (OutValid) sawValid++;
    end
    checkOutput("abandoned op OutValid cycles", 64'(sawValid), 64'd0);

    applyStimulus("and after reset", OP_AND, 64'hF0, 64'h3C, 64'h30, 4'b0000, 1'b0, 1, 0);
    waitIdle("final");
    checkOutput("scoreboard empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
